// File: rtl/servo_pwm_gen.sv
// Fixed-period servo PWM generator with clamped, boundary-synchronous width updates.
// Define SERVO_SLEW_EN to rate-limit width changes to SLEW_STEP_US per period.
module servo_pwm_gen #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int TICK_HZ      = 1_000_000,
  parameter int PERIOD_US    = 20000,
  parameter int MIN_US       = 500,
  parameter int MAX_US       = 2500,
  parameter int SLEW_STEP_US = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] duty_us,
  input  logic        load,
  output logic        pwm_out,
  output logic [15:0] cur_us,
  output logic        period_start
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0] PRESC_LAST  = PW'(DIV - 1);
  localparam logic [15:0]   PERIOD_LAST = 16'(PERIOD_US - 1);
  localparam logic [15:0]   MIN_W       = 16'(MIN_US);
  localparam logic [15:0]   MAX_W       = 16'(MAX_US);
  localparam logic [15:0]   MID_W       = 16'((MIN_US + MAX_US) / 2);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // Reject configurations that cannot produce a legal waveform.
  if (DIV < 2 || MIN_US > MAX_US || MAX_US > PERIOD_US || PERIOD_US > 65536 ||
      SLEW_STEP_US < 1) begin : g_bad_cfg
    $error("servo_pwm_gen: invalid parameter set");
  end

  logic [0:0]    state, state_next;
  logic [PW-1:0] presc, presc_next;
  logic [15:0]   period_cnt, cnt_next;
  logic [15:0]   target, duty_clamped, goal, cur_upd, cur_next;
  logic          tick, boundary, pwm_next, start_next;

  always_comb begin
    if (duty_us < MIN_W)      duty_clamped = MIN_W;
    else if (duty_us > MAX_W) duty_clamped = MAX_W;
    else                      duty_clamped = duty_us;
  end

  // A load landing on a boundary cycle must win over the stale target.
  assign goal = load ? duty_clamped : target;

`ifdef SERVO_SLEW_EN
  localparam logic signed [16:0] STEP_S = 17'(SLEW_STEP_US);
  localparam logic [15:0]        STEP_W = 16'(SLEW_STEP_US);

  logic signed [16:0] diff;

  always_comb begin
    diff = $signed({1'b0, goal}) - $signed({1'b0, cur_us});
    if (diff > STEP_S)       cur_upd = cur_us + STEP_W;
    else if (diff < -STEP_S) cur_upd = cur_us - STEP_W;
    else                     cur_upd = goal;
  end
`else
  assign cur_upd = goal;
`endif

  always_comb begin
    state_next = state;
    presc_next = presc;
    cnt_next   = period_cnt;
    cur_next   = cur_us;
    tick       = 1'b0;
    boundary   = 1'b0;
    start_next = 1'b0;

    case (state)
      IDLE: begin
        presc_next = '0;
        cnt_next   = '0;
        if (en) begin
          state_next = RUN;
          boundary   = 1'b1;
        end
      end
      default: begin
        if (!en) begin
          state_next = IDLE;
          presc_next = '0;
          cnt_next   = '0;
        end else begin
          tick       = (presc == PRESC_LAST);
          presc_next = tick ? '0 : presc + PW'(1);
          if (tick) begin
            if (period_cnt == PERIOD_LAST) begin
              cnt_next = '0;
              boundary = 1'b1;
            end else begin
              cnt_next = period_cnt + 16'd1;
            end
          end
        end
      end
    endcase

    if (boundary) begin
      cur_next   = cur_upd;
      start_next = 1'b1;
    end

    // Output is built from next-state values so it lines up with the count it reflects.
    pwm_next = (state_next == RUN) && (cnt_next < cur_next);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      presc        <= '0;
      period_cnt   <= '0;
      target       <= MID_W;
      cur_us       <= MID_W;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      state        <= state_next;
      presc        <= presc_next;
      period_cnt   <= cnt_next;
      cur_us       <= cur_next;
      pwm_out      <= pwm_next;
      period_start <= start_next;
      if (load) target <= duty_clamped;
    end
  end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed, table-driven bench for servo_pwm_gen using a 10-clock tick and 200-tick period.
module tb_servo_pwm_gen;

  logic        clock = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] duty_us;
  logic        load;
  logic        pwm_out;
  logic [15:0] cur_us;
  logic        period_start;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] duty;
    logic [15:0] exp_cur;
    int          exp_high;
  } vec_t;

  vec_t vecs[7];

  servo_pwm_gen #(
    .CLK_HZ(10_000_000),
    .TICK_HZ(1_000_000),
    .PERIOD_US(200),
    .MIN_US(50),
    .MAX_US(150),
    .SLEW_STEP_US(10)
  ) dut (
    .clock(clock),
    .reset(reset),
    .en(en),
    .duty_us(duty_us),
    .load(load),
    .pwm_out(pwm_out),
    .cur_us(cur_us),
    .period_start(period_start)
  );

  always #50 clock = ~clock;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic apply_stimulus(input logic [15:0] val);
    load    = 1'b1;
    duty_us = val;
    step();
    load    = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (!period_start && n < 2200);
    if (!period_start) check_output({tag, " period_start timeout"}, 0, 1);
  endtask

  // Runs from one period_start cycle to the next, optionally injecting a load at cycle load_at.
  task automatic measure_period(input int load_at, input logic [15:0] load_val,
                                output int high, output int len, output int cur_start);
    high      = 0;
    len       = 0;
    cur_start = int'(cur_us);
    do begin
      if (pwm_out) high++;
      if (len == load_at) begin
        load    = 1'b1;
        duty_us = load_val;
      end
      step();
      load = 1'b0;
      len++;
    end while (!period_start && len < 2200);
  endtask

  task automatic count_activity(input int cycles, output int hits);
    hits = 0;
    repeat (cycles) begin
      step();
      if (pwm_out || period_start) hits++;
    end
  endtask

  initial begin
    int high, len, cs, hits;
`ifdef SERVO_SLEW_EN
    int up_seq[5]  = '{110, 120, 130, 140, 145};
    int dn_seq[10] = '{135, 125, 115, 105, 95, 85, 75, 65, 55, 50};
`endif

    vecs[0] = '{16'd120,   16'd120, 1200};
    vecs[1] = '{16'd10,    16'd50,  500};
    vecs[2] = '{16'd400,   16'd150, 1500};
    vecs[3] = '{16'hFFFF,  16'd150, 1500};
    vecs[4] = '{16'd50,    16'd50,  500};
    vecs[5] = '{16'd150,   16'd150, 1500};
    vecs[6] = '{16'd120,   16'd120, 1200};

    reset   = 1'b1;
    en      = 1'b0;
    load    = 1'b0;
    duty_us = '0;
    #120;
    check_output("reset pwm_out", int'(pwm_out), 0);
    check_output("reset period_start", int'(period_start), 0);
    check_output("reset cur_us", int'(cur_us), 100);
    @(negedge clock);
    reset = 1'b0;
    count_activity(30, hits);
    check_output("idle quiet", hits, 0);

`ifndef SERVO_SLEW_EN
    apply_stimulus(16'd120);
    en = 1'b1;
    step();
    check_output("entry period_start", int'(period_start), 1);
    check_output("entry pwm_out", int'(pwm_out), 1);
    check_output("entry cur_us", int'(cur_us), 120);
    measure_period(-1, 16'd0, high, len, cs);
    check_output("basic high clocks", high, 1200);
    check_output("basic period clocks", len, 2000);

    for (int i = 0; i < 7; i++) begin
      apply_stimulus(vecs[i].duty);
      wait_start($sformatf("vec%0d", i));
      measure_period(-1, 16'd0, high, len, cs);
      check_output($sformatf("vec%0d cur_us", i), cs, int'(vecs[i].exp_cur));
      check_output($sformatf("vec%0d high clocks", i), high, vecs[i].exp_high);
      check_output($sformatf("vec%0d period clocks", i), len, 2000);
    end

    measure_period(300, 16'd60, high, len, cs);
    check_output("midload current cur_us", cs, 120);
    check_output("midload current high", high, 1200);
    measure_period(-1, 16'd0, high, len, cs);
    check_output("midload next cur_us", cs, 60);
    check_output("midload next high", high, 600);

    measure_period(1999, 16'd80, high, len, cs);
    check_output("bypass prior high", high, 600);
    check_output("bypass prior period", len, 2000);
    check_output("bypass cur_us", int'(cur_us), 80);

    repeat (400) step();
    check_output("pre-disable pwm_out", int'(pwm_out), 1);
    en = 1'b0;
    step();
    check_output("disable pwm_out", int'(pwm_out), 0);
    check_output("disable cur_us kept", int'(cur_us), 80);
    count_activity(50, hits);
    check_output("disabled quiet", hits, 0);
    apply_stimulus(16'd130);
    check_output("idle load cur_us", int'(cur_us), 80);
    en = 1'b1;
    step();
    check_output("reenable period_start", int'(period_start), 1);
    check_output("reenable cur_us", int'(cur_us), 130);
    measure_period(-1, 16'd0, high, len, cs);
    check_output("reenable high", high, 1300);
    check_output("reenable period", len, 2000);

    repeat (100) step();
    check_output("pre-reset pwm_out", int'(pwm_out), 1);
    #20;
    reset = 1'b1;
    en    = 1'b0;
    #1;
    check_output("async reset pwm_out", int'(pwm_out), 0);
    check_output("async reset period_start", int'(period_start), 0);
    check_output("async reset cur_us", int'(cur_us), 100);
    @(negedge clock);
    reset = 1'b0;
    count_activity(20, hits);
    check_output("post-reset idle", hits, 0);
    en = 1'b1;
    step();
    check_output("post-reset start", int'(period_start), 1);
    measure_period(-1, 16'd0, high, len, cs);
    check_output("post-reset high", high, 1000);
`else
    en = 1'b1;
    step();
    check_output("slew entry start", int'(period_start), 1);
    check_output("slew entry cur_us", int'(cur_us), 100);
    apply_stimulus(16'd145);
    for (int i = 0; i < 5; i++) begin
      wait_start($sformatf("slew up%0d", i));
      check_output($sformatf("slew up%0d cur_us", i), int'(cur_us), up_seq[i]);
    end
    apply_stimulus(16'd50);
    for (int i = 0; i < 10; i++) begin
      wait_start($sformatf("slew dn%0d", i));
      check_output($sformatf("slew dn%0d cur_us", i), int'(cur_us), dn_seq[i]);
    end
    measure_period(-1, 16'd0, high, len, cs);
    check_output("slew settled high", high, 500);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
